// File: rtl/pointer_key_ctrl.sv
// Five-key pointer front-end: synchronise, debounce, and turn presses into one-cycle step/home pulses.
// Define POINTER_AUTOREPEAT_EN to compile in hold-to-repeat on the four direction keys.
module pointer_key_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] key_n,
  output logic       step_up,
  output logic       step_down,
  output logic       step_left,
  output logic       step_right,
  output logic       home,
  output logic [4:0] held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("pointer_key_ctrl: timing parameters must be at least 1");
  end

`ifdef POINTER_AUTOREPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;
  logic [TW-1:0] timer     [4];
  logic [TW-1:0] timer_nxt [4];
`else
  typedef enum logic {S_IDLE, S_PRESSED} state_t;
`endif

  logic [4:0]    meta;
  logic [4:0]    sync;
  logic [CW-1:0] db_cnt [5];
  logic          home_q;
  logic          home_raw;
  logic [3:0]    raw;
  state_t        state     [4];
  state_t        state_nxt [4];

  // Raw pins are active-low; invert on entry so everything downstream is active-high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      // NOTE: non-blocking so sync samples the old meta, forming a true two-stage chain.
      meta <= ~key_n;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      held <= '0;
      // NOTE: the counter array is plain flops, not RAM; clearing it makes a key still
      // pressed across reset serve a full debounce window again.
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync[i] == held[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          held[i]   <= ~held[i];
          db_cnt[i] <= '0;
        end else if (db_cnt[i] != CW'(DEBOUNCE_CYCLES)) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Direction key FSMs: state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= S_IDLE;
`ifdef POINTER_AUTOREPEAT_EN
        timer[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_nxt[i];
`ifdef POINTER_AUTOREPEAT_EN
        timer[i] <= timer_nxt[i];
`endif
      end
    end
  end

  // Direction key FSMs: next state (and repeat timer).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      // NOTE: hold-by-default assignments keep every path driven, so no latch is inferred.
      state_nxt[i] = state[i];
`ifdef POINTER_AUTOREPEAT_EN
      timer_nxt[i] = timer[i];
      case (state[i])
        S_IDLE: begin
          if (held[i]) begin
            state_nxt[i] = S_DELAY;
            timer_nxt[i] = TW'(REPEAT_DELAY - 1);
          end
        end
        S_DELAY, S_REPEAT: begin
          if (!held[i]) begin
            state_nxt[i] = S_IDLE;
          end else if (timer[i] == '0) begin
            state_nxt[i] = S_REPEAT;
            timer_nxt[i] = TW'(REPEAT_PERIOD - 1);
          end else begin
            timer_nxt[i] = timer[i] - 1'b1;
          end
        end
        default: state_nxt[i] = S_IDLE;
      endcase
`else
      case (state[i])
        S_IDLE:    if (held[i])  state_nxt[i] = S_PRESSED;
        S_PRESSED: if (!held[i]) state_nxt[i] = S_IDLE;
      endcase
`endif
    end
  end

  // Direction key FSMs: raw pulse per key. A release wins over a same-cycle expiry.
  always_comb begin
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      if (state[i] == S_IDLE) begin
        raw[i] = held[i];
      end else begin
`ifdef POINTER_AUTOREPEAT_EN
        raw[i] = held[i] && (timer[i] == '0);
`else
        raw[i] = 1'b0;
`endif
      end
    end
  end

  // Home only fires on the debounced rising edge.
  assign home_raw = held[4] & ~home_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      home_q     <= 1'b0;
      home       <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
    end else begin
      home_q     <= held[4];
      home       <= home_raw;
      step_up    <= raw[0] & ~raw[1] & ~home_raw;
      step_down  <= raw[1] & ~raw[0] & ~home_raw;
      step_left  <= raw[2] & ~raw[3] & ~home_raw;
      step_right <= raw[3] & ~raw[2] & ~home_raw;
    end
  end

endmodule

// File: tb/tb_pointer_key_ctrl.sv
// Self-checking bench for pointer_key_ctrl: directed scenarios plus a random run scored
// every cycle against a window/age-based reference model.
module tb_pointer_key_ctrl;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef POINTER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] key_n  = '1;
  logic       step_up, step_down, step_left, step_right, home;
  logic [4:0] held;

  int n_checks = 0;
  int n_pass   = 0;

  pointer_key_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .key_n     (key_n),
    .step_up   (step_up),
    .step_down (step_down),
    .step_left (step_left),
    .step_right(step_right),
    .home      (home),
    .held      (held)
  );

  always #5 clk = ~clk;

  // Reference model: held flips once the last DB synchronised samples all disagree with it;
  // a direction key pulses at hold-age 0 and, with repeat, at ages RD, RD+RP, RD+2RP, ...
  logic [4:0]    m_s1 = '0, m_s2 = '0, m_held = '0;
  logic [DB-1:0] m_win  [5];
  int            m_fill [5];
  int            m_age  [5];
  logic [9:0]    exp_out = '0;

  always @(posedge clk) begin : model
    logic [4:0] r;
    logic [4:0] nh;
    logic [9:0] act;
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; exp_out = '0;
      for (int i = 0; i < 5; i++) begin
        m_win[i] = '0; m_fill[i] = 0; m_age[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        r[i] = m_held[i] && (m_age[i] == 0 ||
               (AR && m_age[i] >= RD && ((m_age[i] - RD) % RP) == 0));
      r[4] = m_held[4] && m_age[4] == 0;
      exp_out[9] = r[4];
      exp_out[8] = r[3] && !r[2] && !r[4];
      exp_out[7] = r[2] && !r[3] && !r[4];
      exp_out[6] = r[1] && !r[0] && !r[4];
      exp_out[5] = r[0] && !r[1] && !r[4];
      for (int i = 0; i < 5; i++) begin
        m_win[i]  = {m_win[i][DB-2:0], m_s2[i]};
        m_fill[i] = (m_fill[i] < DB) ? m_fill[i] + 1 : DB;
        nh[i] = (m_fill[i] == DB && m_win[i] == {DB{~m_held[i]}}) ? ~m_held[i] : m_held[i];
        m_age[i] = (nh[i] && m_held[i]) ? m_age[i] + 1 : 0;
      end
      exp_out[4:0] = nh;
      m_held = nh;
      m_s2   = m_s1;
      m_s1   = ~key_n;
    end
    #1;
    act = {home, step_right, step_left, step_down, step_up, held};
    n_checks++;
    if (act !== exp_out)
      $display("FAIL model_cycle t=%0t outputs {home,r,l,d,u,held}=%b expected %b", $time, act, exp_out);
    else
      n_pass++;
  end

  task automatic release_all();
    @(negedge clk);
    key_n = '1;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    key_n  = '1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({home, step_right, step_left, step_down, step_up, held} !== 10'b0)
      $display("FAIL reset_outputs got %b expected 0",
               {home, step_right, step_left, step_down, step_up, held});
    else n_pass++;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_press();
    int first = -1, npulse = 0, hrise = -1, hfall = -1;
    @(negedge clk);
    key_n[3] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (step_right) begin npulse++; if (first < 0) first = c; end
      if (held[3] && hrise < 0) hrise = c;
      if (!held[3] && hrise >= 0 && hfall < 0) hfall = c;
      @(negedge clk);
      if (c == 7) key_n[3] = 1'b1;
    end
    n_checks++;
    if (first !== 7) $display("FAIL press_latency step_right cycle %0d expected 7", first);
    else n_pass++;
    n_checks++;
    if (npulse !== 1) $display("FAIL press_count step_right pulses %0d expected 1", npulse);
    else n_pass++;
    n_checks++;
    if (hrise !== 6) $display("FAIL held_rise held[3] rose at %0d expected 6", hrise);
    else n_pass++;
    n_checks++;
    if (hfall !== 13) $display("FAIL held_fall held[3] fell at %0d expected 13", hfall);
    else n_pass++;
    release_all();
  endtask

  task automatic test_bounce();
    int bad = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      key_n[0] = (c < 25 && (c % 5) < 3) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (held[0] || step_up) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL bounce_reject %0d cycles with held[0]/step_up set, expected 0", bad);
    else n_pass++;
    n_checks++;
    if (held[0] !== 1'b0) $display("FAIL bounce_held held[0]=%b expected 0", held[0]);
    else n_pass++;
    release_all();
  endtask

  task automatic test_autorepeat();
    int exp_q[$];
    int got_q[$];
    int first = -1;
    exp_q.push_back(7);
    if (AR) for (int a = RD; 6 + a <= 36 + 5; a += RP) exp_q.push_back(7 + a);
    @(negedge clk);
    key_n[2] = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (step_left) got_q.push_back(c);
      @(negedge clk);
      if (c == 36) key_n[2] = 1'b1;
    end
    n_checks++;
    if (got_q.size() !== exp_q.size())
      $display("FAIL repeat_count step_left pulses %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    if (got_q.size() == exp_q.size())
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (got_q[k] !== exp_q[k])
          $display("FAIL repeat_time pulse %0d at cycle %0d expected %0d", k, got_q[k], exp_q[k]);
        else n_pass++;
      end
    release_all();
    // A fresh press after release must start over from the initial pulse.
    key_n[2] = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (step_left && first < 0) first = c;
      @(negedge clk);
    end
    n_checks++;
    if (first !== 7) $display("FAIL repress_latency step_left cycle %0d expected 7", first);
    else n_pass++;
    release_all();
  endtask

  task automatic test_opposing();
    int bad = 0;
    @(negedge clk);
    key_n[1:0] = 2'b00;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (step_up || step_down) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0) $display("FAIL opposing_drop %0d cycles with step_up/down set, expected 0", bad);
    else n_pass++;
    n_checks++;
    if (held[1:0] !== 2'b11) $display("FAIL opposing_held held[1:0]=%b expected 11", held[1:0]);
    else n_pass++;
    release_all();
  endtask

  task automatic test_home_priority();
    int nhome = 0, nright = 0;
    @(negedge clk);
    key_n[4] = 1'b0;
    key_n[3] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (home) nhome++;
      if (step_right) nright++;
      if (c == 7) begin
        n_checks++;
        if (home !== 1'b1) $display("FAIL home_pulse home=%b at cycle 7 expected 1", home);
        else n_pass++;
        n_checks++;
        if (step_right !== 1'b0) $display("FAIL home_priority step_right=%b at cycle 7 expected 0", step_right);
        else n_pass++;
      end
      @(negedge clk);
      if (c == 8)  key_n[3] = 1'b1;
      if (c == 40) key_n[4] = 1'b1;
    end
    n_checks++;
    if (nhome !== 1) $display("FAIL home_once home pulses %0d expected 1", nhome);
    else n_pass++;
    n_checks++;
    if (nright !== 0) $display("FAIL home_right step_right pulses %0d expected 0", nright);
    else n_pass++;
    release_all();
  endtask

  task automatic test_reset_mid_repeat();
    int first = -1, hrise = -1;
    @(negedge clk);
    key_n[3] = 1'b0;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({home, step_right, step_left, step_down, step_up, held} !== 10'b0)
      $display("FAIL midreset_outputs got %b expected 0",
               {home, step_right, step_left, step_down, step_up, held});
    else n_pass++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (step_right && first < 0) first = c;
      if (held[3] && hrise < 0) hrise = c;
      @(negedge clk);
    end
    n_checks++;
    if (first !== 7) $display("FAIL midreset_latency step_right cycle %0d expected 7", first);
    else n_pass++;
    n_checks++;
    if (hrise !== 6) $display("FAIL midreset_held held[3] rose at %0d expected 6", hrise);
    else n_pass++;
    release_all();
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, 4)] ^= 1'b1;
      if (c == 1200) resetn = 1'b0;
      if (c == 1203) resetn = 1'b1;
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_autorepeat();
    test_opposing();
    test_home_priority();
    test_reset_mid_repeat();
    test_random();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
